// File: rtl/cmp_unit_pipe.sv
// Pipelined signed/unsigned compare unit with eight compare/select functions.
// Two register stages with valid/ready backpressure and a saturating true-result counter.
module cmp_unit_pipe #(
   parameter int DATA_WIDTH = 16,
   parameter int OUT_WIDTH  = 16,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] B,
   input  logic [2:0]            ALU_FUN,
   input  logic                  SIGNED_MODE,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic                  OUT_VALID,
   input  logic                  OUT_READY,
   output logic [OUT_WIDTH-1:0]  CMP_OUT,
   output logic                  CMP_Flag,
   input  logic                  CNT_CLR,
   output logic [CNT_WIDTH-1:0]  MATCH_CNT
);

   localparam logic [2:0] FUN_NOP = 3'd0;
   localparam logic [2:0] FUN_EQ  = 3'd1;
   localparam logic [2:0] FUN_GT  = 3'd2;
   localparam logic [2:0] FUN_LT  = 3'd3;
   localparam logic [2:0] FUN_GE  = 3'd4;
   localparam logic [2:0] FUN_LE  = 3'd5;
   localparam logic [2:0] FUN_MIN = 3'd6;
   localparam logic [2:0] FUN_MAX = 3'd7;

   logic                  s1_valid_q;
   logic [DATA_WIDTH-1:0] s1_a_q, s1_b_q;
   logic [2:0]            s1_fun_q;
   logic                  s1_sgn_q;

   logic                  out_valid_q;
   logic [OUT_WIDTH-1:0]  cmp_out_q;
   logic                  flag_q;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  s1_load, s2_load;
   logic                  eq, lt;
   logic [DATA_WIDTH-1:0] sel;
   logic [OUT_WIDTH-1:0]  res_d;
   logic                  flag_d;

   assign s2_load  = !out_valid_q || OUT_READY;
   assign s1_load  = !s1_valid_q || s2_load;
   assign IN_READY = s1_load;

   // One extra top bit carries the sign in signed mode, zero in unsigned mode.
   assign eq = (s1_a_q == s1_b_q);
   assign lt = $signed({s1_sgn_q & s1_a_q[DATA_WIDTH-1], s1_a_q}) <
               $signed({s1_sgn_q & s1_b_q[DATA_WIDTH-1], s1_b_q});

   always_comb begin
      res_d  = '0;
      flag_d = 1'b0;
      sel    = s1_a_q;
      case (s1_fun_q)
         FUN_NOP: flag_d = 1'b0;
         FUN_EQ:  flag_d = eq;
         FUN_GT:  flag_d = !lt && !eq;
         FUN_LT:  flag_d = lt;
         FUN_GE:  flag_d = !lt;
         FUN_LE:  flag_d = lt || eq;
         FUN_MIN: flag_d = lt || eq;
         FUN_MAX: flag_d = !lt;
         default: flag_d = 1'b0;
      endcase
      if (s1_fun_q == FUN_MIN || s1_fun_q == FUN_MAX) begin
         sel = flag_d ? s1_a_q : s1_b_q;
         if (s1_sgn_q) res_d = OUT_WIDTH'($signed(sel));
         else          res_d = OUT_WIDTH'(sel);
      end else if (flag_d) begin
         res_d = OUT_WIDTH'(s1_fun_q);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_fun_q   <= FUN_NOP;
         s1_sgn_q   <= 1'b0;
      end else if (s1_load) begin
         s1_valid_q <= IN_VALID;
         if (IN_VALID) begin
            s1_a_q   <= A;
            s1_b_q   <= B;
            s1_fun_q <= ALU_FUN;
            s1_sgn_q <= SIGNED_MODE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_valid_q <= 1'b0;
         cmp_out_q   <= '0;
         flag_q      <= 1'b0;
      end else if (s2_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            cmp_out_q <= res_d;
            flag_q    <= flag_d;
         end
      end
   end

   // Clear wins over a same-cycle increment; increment saturates at all-ones.
   always_comb begin
      cnt_d = cnt_q;
      if (CNT_CLR)
         cnt_d = '0;
      else if (out_valid_q && OUT_READY && flag_q && (cnt_q != {CNT_WIDTH{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign OUT_VALID = out_valid_q;
   assign CMP_OUT   = cmp_out_q;
   assign CMP_Flag  = flag_q;
   assign MATCH_CNT = cnt_q;

endmodule

// File: tb/tb_cmp_unit_pipe.sv
// Bench for cmp_unit_pipe: directed vectors with literal expectations plus a
// per-cycle scoreboard fed by an arithmetic model of the compare functions.
module tb_cmp_unit_pipe;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [15:0] A = '0, B = '0;
   logic [2:0]  ALU_FUN = '0;
   logic        SIGNED_MODE = 1'b0, IN_VALID = 1'b0, OUT_READY = 1'b0, CNT_CLR = 1'b0;

   logic        IN_READY, OUT_VALID, CMP_Flag;
   logic [15:0] CMP_OUT;
   logic [1:0]  MATCH_CNT;

   logic        n_IN_READY, n_OUT_VALID, n_CMP_Flag;
   logic [11:0] n_CMP_OUT;
   logic [7:0]  n_MATCH_CNT;

   int n_checks = 0;
   int n_pass   = 0;
   int delivered = 0;

   always #5 CLK = ~CLK;

   cmp_unit_pipe #(.DATA_WIDTH(16), .OUT_WIDTH(16), .CNT_WIDTH(2)) u_dut (
      .CLK(CLK), .RST(RST), .A(A), .B(B), .ALU_FUN(ALU_FUN), .SIGNED_MODE(SIGNED_MODE),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag), .CNT_CLR(CNT_CLR), .MATCH_CNT(MATCH_CNT));

   // Narrow data into a wider result: exercises sign/zero extension.
   cmp_unit_pipe #(.DATA_WIDTH(8), .OUT_WIDTH(12), .CNT_WIDTH(8)) u_dut_n (
      .CLK(CLK), .RST(RST), .A(A[7:0]), .B(B[7:0]), .ALU_FUN(ALU_FUN), .SIGNED_MODE(SIGNED_MODE),
      .IN_VALID(IN_VALID), .IN_READY(n_IN_READY), .OUT_VALID(n_OUT_VALID), .OUT_READY(OUT_READY),
      .CMP_OUT(n_CMP_OUT), .CMP_Flag(n_CMP_Flag), .CNT_CLR(CNT_CLR), .MATCH_CNT(n_MATCH_CNT));

   typedef struct { logic [31:0] out; logic flag; } exp_t;
   typedef struct { logic [15:0] a; logic [15:0] b; logic [2:0] f; logic s; } tx_t;

   exp_t q16[$];
   exp_t q8[$];
   int   mcnt16 = 0, mcnt8 = 0;
   logic stall_prev = 1'b0, n_stall_prev = 1'b0;
   logic [15:0] prev_out;
   logic [11:0] n_prev_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Operands interpreted as integers of width dw; result masked to ow bits.
   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                                  input logic s, input int dw, input int ow);
      exp_t   e;
      longint av, bv, sel, m;
      m  = (longint'(1) << dw) - 1;
      av = longint'(a) & m;
      bv = longint'(b) & m;
      if (s && (((av >> (dw - 1)) & 1) == 1)) av = av - (longint'(1) << dw);
      if (s && (((bv >> (dw - 1)) & 1) == 1)) bv = bv - (longint'(1) << dw);
      e.flag = 1'b0;
      e.out  = '0;
      sel    = 0;
      case (f)
         3'd1: e.flag = (av == bv);
         3'd2: e.flag = (av >  bv);
         3'd3: e.flag = (av <  bv);
         3'd4: e.flag = (av >= bv);
         3'd5: e.flag = (av <= bv);
         3'd6: e.flag = (av <= bv);
         3'd7: e.flag = (av >= bv);
         default: e.flag = 1'b0;
      endcase
      if (f >= 3'd6) begin
         sel   = e.flag ? av : bv;
         e.out = 32'(sel & ((longint'(1) << ow) - 1));
      end else if (e.flag) begin
         e.out = 32'(f);
      end
      return e;
   endfunction

   // Scoreboard: inputs are stable at the falling edge, so handshakes seen here
   // are exactly the transfers the next rising edge performs.
   always @(negedge CLK) begin
      exp_t e;
      logic pop16, pop8;
      if (!RST) begin
         q16.delete(); q8.delete();
         mcnt16 = 0; mcnt8 = 0;
         stall_prev = 1'b0; n_stall_prev = 1'b0;
      end else begin
         chk("in_ready", 32'(IN_READY), 32'((q16.size() < 2) || OUT_READY));
         chk("n_in_ready", 32'(n_IN_READY), 32'((q8.size() < 2) || OUT_READY));
         if (q16.size() == 2) chk("out_valid_full", 32'(OUT_VALID), 32'd1);
         if (OUT_VALID) begin
            if (q16.size() == 0) chk("spurious_out", 32'd1, 32'd0);
            else begin
               chk("cmp_out", 32'(CMP_OUT), q16[0].out);
               chk("cmp_flag", 32'(CMP_Flag), 32'(q16[0].flag));
            end
         end
         if (n_OUT_VALID) begin
            if (q8.size() == 0) chk("n_spurious_out", 32'd1, 32'd0);
            else begin
               chk("n_cmp_out", 32'(n_CMP_OUT), q8[0].out);
               chk("n_cmp_flag", 32'(n_CMP_Flag), 32'(q8[0].flag));
            end
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(OUT_VALID), 32'd1);
            chk("stall_hold", 32'(CMP_OUT), 32'(prev_out));
         end
         if (n_stall_prev) chk("n_stall_hold", 32'(n_CMP_OUT), 32'(n_prev_out));
         chk("match_cnt", 32'(MATCH_CNT), 32'(mcnt16));
         chk("n_match_cnt", 32'(n_MATCH_CNT), 32'(mcnt8));

         pop16 = 1'b0; pop8 = 1'b0;
         if (OUT_VALID && OUT_READY && q16.size() > 0) begin
            e = q16.pop_front(); pop16 = e.flag; delivered++;
         end
         if (n_OUT_VALID && OUT_READY && q8.size() > 0) begin
            e = q8.pop_front(); pop8 = e.flag;
         end
         if (CNT_CLR) begin
            mcnt16 = 0; mcnt8 = 0;
         end else begin
            if (pop16 && mcnt16 < 3)  mcnt16++;
            if (pop8  && mcnt8 < 255) mcnt8++;
         end
         if (IN_VALID && IN_READY)   q16.push_back(model(A, B, ALU_FUN, SIGNED_MODE, 16, 16));
         if (IN_VALID && n_IN_READY) q8.push_back(model(A, B, ALU_FUN, SIGNED_MODE, 8, 12));
         stall_prev   = OUT_VALID && !OUT_READY;
         n_stall_prev = n_OUT_VALID && !OUT_READY;
         prev_out     = CMP_OUT;
         n_prev_out   = n_CMP_OUT;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present one transaction, then check the exact latency and literal result.
   task automatic send_one(input logic [15:0] a, input logic [15:0] b, input logic [2:0] f,
                           input logic s, input logic [15:0] exp_out, input logic exp_flag);
      int n;
      A = a; B = b; ALU_FUN = f; SIGNED_MODE = s; IN_VALID = 1'b1; OUT_READY = 1'b1;
      #1;
      n = 0;
      while (!IN_READY && n < 20) begin tick(); n++; end
      if (n >= 20) chk("accept_timeout", 32'd0, 32'd1);
      tick();
      IN_VALID = 1'b0;
      chk("latency_not_early", 32'(OUT_VALID), 32'd0);
      tick();
      chk("latency_valid", 32'(OUT_VALID), 32'd1);
      chk("lit_out", 32'(CMP_OUT), 32'(exp_out));
      chk("lit_flag", 32'(CMP_Flag), 32'(exp_flag));
      tick();
   endtask

   tx_t st[6];
   int  cyc, idx, start;
   logic acc, sawlow;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(); tick();
      chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("rst_cmp_out", 32'(CMP_OUT), 32'd0);
      chk("rst_flag", 32'(CMP_Flag), 32'd0);
      chk("rst_match_cnt", 32'(MATCH_CNT), 32'd0);
      RST = 1'b1;
      #1;
      chk("rst_in_ready", 32'(IN_READY), 32'd1);
      tick();

      send_one(16'h0005, 16'h0005, 3'b001, 1'b0, 16'h0001, 1'b1);
      chk("lit_cnt_first", 32'(MATCH_CNT), 32'd1);
      send_one(16'hFFFF, 16'h0001, 3'b011, 1'b1, 16'h0003, 1'b1);
      send_one(16'hFFFF, 16'h0001, 3'b011, 1'b0, 16'h0000, 1'b0);
      send_one(16'h8000, 16'h7FFF, 3'b110, 1'b1, 16'h8000, 1'b1);
      send_one(16'h8000, 16'h7FFF, 3'b110, 1'b0, 16'h7FFF, 1'b0);
      send_one(16'h0042, 16'h0042, 3'b111, 1'b0, 16'h0042, 1'b1);
      send_one(16'h0003, 16'h0002, 3'b010, 1'b0, 16'h0002, 1'b1);
      send_one(16'h0002, 16'h0003, 3'b100, 1'b0, 16'h0000, 1'b0);
      send_one(16'h8000, 16'h0001, 3'b101, 1'b1, 16'h0005, 1'b1);
      send_one(16'hFFFE, 16'h0001, 3'b111, 1'b1, 16'h0001, 1'b0);
      send_one(16'h1234, 16'h1234, 3'b000, 1'b0, 16'h0000, 1'b0);

      // Six back-to-back transfers, consumer stalled in cycles 3..6.
      st[0] = '{16'h0005, 16'h0005, 3'd1, 1'b0};
      st[1] = '{16'hFFFF, 16'h0001, 3'd3, 1'b1};
      st[2] = '{16'h8000, 16'h7FFF, 3'd6, 1'b1};
      st[3] = '{16'h8000, 16'h7FFF, 3'd6, 1'b0};
      st[4] = '{16'h0042, 16'h0042, 3'd7, 1'b0};
      st[5] = '{16'hFFFE, 16'h0001, 3'd7, 1'b1};
      start = delivered; idx = 0; sawlow = 1'b0;
      for (cyc = 0; cyc < 40 && delivered < start + 6; cyc++) begin
         OUT_READY = !(cyc >= 3 && cyc <= 6);
         if (idx < 6) begin
            IN_VALID = 1'b1; A = st[idx].a; B = st[idx].b;
            ALU_FUN = st[idx].f; SIGNED_MODE = st[idx].s;
         end else IN_VALID = 1'b0;
         #1;
         acc = IN_VALID && IN_READY;
         if (!IN_READY) sawlow = 1'b1;
         tick();
         if (acc) idx++;
      end
      IN_VALID = 1'b0; OUT_READY = 1'b1;
      chk("stream_ready_dropped", 32'(sawlow), 32'd1);
      chk("stream_all_accepted", 32'(idx), 32'd6);
      chk("stream_cycles", 32'(cyc), 32'd12);

      // Saturation with a 2-bit counter.
      CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
      chk("lit_cnt_cleared", 32'(MATCH_CNT), 32'd0);
      A = 16'h0007; B = 16'h0007; ALU_FUN = 3'd1; SIGNED_MODE = 1'b0;
      IN_VALID = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      IN_VALID = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("lit_cnt_saturated", 32'(MATCH_CNT), 32'd3);

      // Clear on the same cycle as a true output transfer.
      IN_VALID = 1'b1; tick(); IN_VALID = 1'b0; tick();
      chk("clr_case_valid", 32'(OUT_VALID), 32'd1);
      CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
      chk("lit_cnt_clr_wins", 32'(MATCH_CNT), 32'd0);
      chk("clr_case_consumed", 32'(OUT_VALID), 32'd0);

      // Reset with two transactions in flight.
      send_one(16'h0009, 16'h0009, 3'b001, 1'b0, 16'h0001, 1'b1);
      chk("lit_cnt_before_rst", 32'(MATCH_CNT), 32'd1);
      OUT_READY = 1'b0;
      A = 16'h0001; B = 16'h0002; ALU_FUN = 3'd3; IN_VALID = 1'b1; tick();
      A = 16'h0004; B = 16'h0004; ALU_FUN = 3'd1; tick();
      IN_VALID = 1'b0;
      chk("inflight_valid", 32'(OUT_VALID), 32'd1);
      RST = 1'b0;
      #1;
      chk("arst_out_valid", 32'(OUT_VALID), 32'd0);
      chk("arst_cmp_out", 32'(CMP_OUT), 32'd0);
      chk("arst_flag", 32'(CMP_Flag), 32'd0);
      chk("arst_match_cnt", 32'(MATCH_CNT), 32'd0);
      tick(); tick();
      RST = 1'b1; OUT_READY = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_idle", 32'(OUT_VALID), 32'd0);
      end
      send_one(16'h8000, 16'h0001, 3'b010, 1'b0, 16'h0002, 1'b1);
      tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
